// File: rtl/twiddle_loader_pkg.sv
// Shared FFT package: default twiddle geometry, Q1.10 unity constant and
// the loader state encoding.
package twiddle_loader_pkg;

  localparam int TW_WIDTH  = 12;
  localparam int TW_DEPTH  = 8;
  localparam int TW_STAGES = 3;

  // 1.0 in Q1.10
  localparam logic [11:0] TW_ONE = 12'h400;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } tw_state_e;

endpackage

// File: rtl/tw_addr_counter.sv
// Wrapping enable counter with synchronous clear. Counts 0..MODULUS-1 and
// wraps back to 0. Used for both the table write pointer and the read address.
module tw_addr_counter #(
  parameter int MODULUS = 8,
  parameter int CW      = $clog2(MODULUS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  // Clear (or reset) wins over enable; enable steps the count with wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == CW'(MODULUS - 1)) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/twiddle_loader.sv
// Twiddle coefficient loader: streams STAGES*DEPTH words into a table,
// then serves them per stage with a wrapping read address. The table itself
// is never cleared; it only becomes readable after a complete load.
module twiddle_loader
  import twiddle_loader_pkg::*;
#(
  parameter int WIDTH  = TW_WIDTH,
  parameter int DEPTH  = TW_DEPTH,
  parameter int STAGES = TW_STAGES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    wr_valid,
  input  logic signed [WIDTH-1:0] wr_data,
  output logic                    wr_ready,
  output logic                    loaded,
  input  logic [1:0]              rd_stage,
  input  logic                    enable,
  output logic signed [WIDTH-1:0] mem_out
);

  localparam int TOTAL  = STAGES * DEPTH;
  localparam int PTR_W  = $clog2(TOTAL);
  localparam int ADDR_W = $clog2(DEPTH);

  tw_state_e               state;
  logic [PTR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]       rd_addr;
  logic [PTR_W-1:0]        rd_index;
  logic                    accept;
  logic                    last_word;
  logic                    stage_ok;
  logic                    rd_step;
  logic signed [WIDTH-1:0] table_mem [TOTAL];

  // A restart request outranks a write arriving in the same cycle.
  assign accept    = wr_valid && wr_ready && !load_start;
  assign last_word = accept && (wr_ptr == PTR_W'(TOTAL - 1));
  assign rd_step   = (state == READY) && enable;
  assign wr_ready  = (state == LOAD);
  assign loaded    = (state == READY);
  assign stage_ok  = (int'(rd_stage) < STAGES);
  assign rd_index  = PTR_W'(rd_stage) * PTR_W'(DEPTH) + PTR_W'(rd_addr);

  // Load control: any load_start (re)enters LOAD, the final word moves to READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else if (load_start) begin
      state <= LOAD;
    end else if (last_word) begin
      state <= READY;
    end
  end

  // Coefficient storage, written in stage-major order; deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      table_mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer restarts on every load_start and steps per accepted word.
  tw_addr_counter #(.MODULUS(TOTAL), .CW(PTR_W)) u_wr_ptr (
    .clk    (clk),
    .reset  (reset),
    .clear  (load_start),
    .enable (accept),
    .count  (wr_ptr)
  );

  // Read address starts at 0 on entry to READY and only moves while READY.
  tw_addr_counter #(.MODULUS(DEPTH), .CW(ADDR_W)) u_rd_addr (
    .clk    (clk),
    .reset  (reset),
    .clear  (last_word),
    .enable (rd_step),
    .count  (rd_addr)
  );

  // Zero-latency table read; zero whenever the table is not valid or stage is out of range.
  always_comb begin
    mem_out = '0;
    if (state == READY && stage_ok) begin
      mem_out = table_mem[rd_index];
    end
  end

endmodule

// File: tb/tb_twiddle_loader.sv
// Scoreboard bench for twiddle_loader: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_twiddle_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        wr_valid;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        loaded;
  logic [1:0]  rd_stage;
  logic        enable;
  logic [11:0] mem_out;

  int n_cmp = 0;
  int n_err = 0;

  int          kind_q[$];
  logic [11:0] val_q[$];
  string       name_q[$];

  logic [11:0] tbl_a [24];
  logic [11:0] tbl_b [24];
  logic [11:0] model [24];
  int          m_addr;

  twiddle_loader #(.WIDTH(12), .DEPTH(8), .STAGES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .loaded     (loaded),
    .rd_stage   (rd_stage),
    .enable     (enable),
    .mem_out    (mem_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    while (kind_q.size() > 0) begin
      int          k;
      logic [11:0] exp_v;
      logic [11:0] act_v;
      string       nm;
      k     = kind_q.pop_front();
      exp_v = val_q.pop_front();
      nm    = name_q.pop_front();
      case (k)
        0:       act_v = mem_out;
        1:       act_v = {11'd0, loaded};
        default: act_v = {11'd0, wr_ready};
      endcase
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL %s: got 0x%03h expected 0x%03h at %0t", nm, act_v, exp_v, $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int kind, input logic [11:0] v, input string nm);
    kind_q.push_back(kind);
    val_q.push_back(v);
    name_q.push_back(nm);
  endtask

  function automatic logic [11:0] exp_read(input int stage, input int addr);
    if (stage >= 3) return 12'h000;
    return model[stage * 8 + addr];
  endfunction

  // Issues the load_start cycle; leaves the bench in the first LOAD cycle.
  task automatic start_load();
    load_start = 1'b1;
    wr_valid   = 1'b0;
    cyc();
    load_start = 1'b0;
    expect_out(2, 12'h001, "wr_ready_in_load");
    expect_out(1, 12'h000, "loaded_in_load");
    expect_out(0, 12'h000, "mem_out_in_load");
  endtask

  // Feeds n words from table A or B starting at entry 0, optionally with gaps.
  task automatic feed(input bit use_b, input bit gaps, input int n, input bit hold_after);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 1000) begin
      guard++;
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = use_b ? tbl_b[i] : tbl_a[i];
      if (wr_valid) begin
        model[i] = wr_data;
        i++;
        if (i == 24) expect_out(1, 12'h000, "loaded_before_last");
      end
      cyc();
    end
    wr_valid = 1'b0;
    if (n == 24) begin
      m_addr   = 0;
      enable   = 1'b0;
      wr_valid = hold_after;
      wr_data  = 12'hFFF;
      expect_out(1, 12'h001, "loaded_after_last");
      expect_out(2, 12'h000, "wr_ready_in_ready");
      expect_out(0, exp_read(int'(rd_stage), 0), "mem_out_entry0");
      cyc();
      if (hold_after) begin
        cyc();
        cyc();
        wr_valid = 1'b0;
      end
    end
  endtask

  // Reads n_en+1 consecutive addresses of a stage, stepping with enable.
  task automatic read_check(input int stage, input int n_en);
    rd_stage = 2'(stage);
    for (int k = 0; k <= n_en; k++) begin
      enable = (k < n_en);
      expect_out(0, exp_read(stage, m_addr), $sformatf("read_s%0d_a%0d", stage, m_addr));
      cyc();
      if (enable) m_addr = (m_addr + 1) % 8;
    end
    enable = 1'b0;
  endtask

  task automatic read_all();
    for (int s = 0; s < 3; s++) read_check(s, 8);
  endtask

  initial begin
    tbl_a = '{12'h400, 12'h2D4, 12'h000, 12'hD2B, 12'h3B2, 12'h187, 12'hE78, 12'hC4D,
              12'h400, 12'h3B2, 12'h2D4, 12'h187, 12'h000, 12'hE78, 12'hD2B, 12'hC4D,
              12'h400, 12'h0C9, 12'h2D4, 12'h3B2, 12'h000, 12'hF37, 12'hD2B, 12'hE0C};
    for (int i = 0; i < 24; i++) tbl_b[i] = 12'((i + 1) * 16);
    for (int i = 0; i < 24; i++) model[i] = 12'h000;
    m_addr     = 0;
    reset      = 1'b1;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 12'h000;
    rd_stage   = 2'd0;
    enable     = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    expect_out(1, 12'h000, "reset_loaded");
    expect_out(2, 12'h000, "reset_wr_ready");
    expect_out(0, 12'h000, "reset_mem_out");
    cyc();

    // Writes while EMPTY are refused.
    wr_valid = 1'b1;
    wr_data  = 12'h123;
    expect_out(2, 12'h000, "empty_wr_ready");
    cyc();
    wr_valid = 1'b0;

    // Full ungapped load of table A, stage 0 read with wrap.
    start_load();
    feed(1'b0, 1'b0, 24, 1'b0);
    read_check(0, 8);

    // Stage select: move to address 5, then look at stage 2 and stage 3.
    rd_stage = 2'd0;
    for (int k = 0; k < 5; k++) begin
      enable = 1'b1;
      cyc();
      m_addr = (m_addr + 1) % 8;
    end
    enable   = 1'b0;
    rd_stage = 2'd2;
    expect_out(0, 12'hF37, "stage2_addr5");
    cyc();
    rd_stage = 2'd3;
    expect_out(0, 12'h000, "stage3_zero");
    cyc();
    rd_stage = 2'd0;

    // Reload from READY with enable asserted throughout.
    load_start = 1'b1;
    enable     = 1'b1;
    expect_out(1, 12'h001, "loaded_on_start_cycle");
    cyc();
    load_start = 1'b0;
    expect_out(1, 12'h000, "reload_loaded_drop");
    expect_out(0, 12'h000, "reload_mem_out_zero");
    expect_out(2, 12'h001, "reload_wr_ready");
    feed(1'b1, 1'b0, 24, 1'b0);
    read_all();

    // Gapped load of A, then wr_valid held high after completion.
    start_load();
    feed(1'b0, 1'b1, 24, 1'b1);
    read_all();

    // Reset after 10 words, then a clean full load.
    start_load();
    feed(1'b1, 1'b0, 10, 1'b0);
    reset = 1'b1;
    cyc();
    reset    = 1'b0;
    wr_valid = 1'b1;
    expect_out(1, 12'h000, "midreset_loaded");
    expect_out(2, 12'h000, "midreset_wr_ready");
    expect_out(0, 12'h000, "midreset_mem_out");
    cyc();
    wr_valid = 1'b0;
    start_load();
    feed(1'b0, 1'b0, 24, 1'b0);
    read_all();

    // Collision: load_start together with a valid word mid-load.
    start_load();
    feed(1'b1, 1'b0, 5, 1'b0);
    load_start = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 12'h555;
    cyc();
    load_start = 1'b0;
    wr_valid   = 1'b0;
    expect_out(2, 12'h001, "collide_wr_ready");
    expect_out(1, 12'h000, "collide_loaded");
    feed(1'b1, 1'b0, 24, 1'b0);
    read_all();

    cyc();
    @(negedge clk);
    #1;
    if (kind_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", kind_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
